// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a bit-timing
// state machine that sends start, 8 data bits LSB first, and one stop bit.
// Rev    : 1.0
// ============================================================================

module uart_tx #(
  parameter int CLK_DIVIDE = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_serialOut,
  output logic       o_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);
  localparam logic [15:0]   C_LAST_TICK = 16'(CLK_DIVIDE - 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_DATA  = 2'd2;
  localparam logic [1:0] C_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [15:0]   r_clk_count;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_serial;

  logic w_push;
  logic w_pop;
  logic w_bit_end;
  logic w_fifo_nonempty;

  assign o_ready         = (r_count != C_FULL);
  assign o_busy          = (r_state != C_IDLE) || (r_count != '0);
  assign o_serialOut     = r_serial;
  assign w_fifo_nonempty = (r_count != '0);
  assign w_bit_end       = (r_clk_count == C_LAST_TICK);

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign w_push = i_valid && o_ready;
  assign w_pop  = w_fifo_nonempty &&
                  ((r_state == C_IDLE) || ((r_state == C_STOP) && w_bit_end));

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= C_IDLE;
      r_clk_count <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_serial    <= 1'b1;
    end else begin
      case (r_state)
        C_IDLE: begin
          r_serial <= 1'b1;
          if (w_pop) begin
            r_shift     <= r_mem[r_rd_ptr];
            r_bit_idx   <= '0;
            r_clk_count <= '0;
            r_serial    <= 1'b0;
            r_state     <= C_START;
          end
        end
        C_START: begin
          if (w_bit_end) begin
            r_clk_count <= '0;
            r_serial    <= r_shift[0];
            r_state     <= C_DATA;
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end
        C_DATA: begin
          if (w_bit_end) begin
            r_clk_count <= '0;
            if (r_bit_idx == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= C_STOP;
            end else begin
              // The bit on the line is always shift[0]; shift to expose the next.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_serial  <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end
        C_STOP: begin
          if (w_bit_end) begin
            r_clk_count <= '0;
            if (w_pop) begin
              r_shift   <= r_mem[r_rd_ptr];
              r_bit_idx <= '0;
              r_serial  <= 1'b0;
              r_state   <= C_START;
            end else begin
              r_state <= C_IDLE;
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end
        default: begin
          r_state     <= C_IDLE;
          r_clk_count <= '0;
          r_serial    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx
// Self-checking bench for uart_tx: frame-level reference model plus a line
// receiver, with directed scenarios and a randomized traffic phase.
// Rev    : 1.0
// ============================================================================

module tb_uart_tx;

  localparam int D     = 8;
  localparam int DEPTH = 4;
  localparam int DS    = 868;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, serial, busy;
  logic       valid_s = 1'b0;
  logic [7:0] data_s = 8'h00;
  logic       ready_s, serial_s, busy_s;

  always #5 clk = ~clk;

  uart_tx #(.CLK_DIVIDE(D), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready), .o_serialOut(serial), .o_busy(busy)
  );

  uart_tx #(.CLK_DIVIDE(DS), .FIFO_DEPTH(DEPTH)) dut_slow (
    .i_clk(clk), .i_reset(rst), .i_valid(valid_s), .i_data(data_s),
    .o_ready(ready_s), .o_serialOut(serial_s), .o_busy(busy_s)
  );

  int tests_run = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the position within the current frame.
  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur;
  bit         in_frame = 0;
  int         pos = 0;
  bit         popped_full = 0;

  bit         rx_active = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    int idx;
    idx = p / D;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic step();
    int  pre;
    bit  push;
    @(posedge clk);
    popped_full = 0;
    if (rst) begin
      fifo_q.delete();
      in_frame = 0;
      pos = 0;
    end else begin
      pre  = fifo_q.size();
      push = valid && (pre != DEPTH);
      if (!in_frame) begin
        if (pre != 0) begin
          cur = fifo_q.pop_front();
          in_frame = 1;
          pos = 0;
        end
      end else if (pos == 10*D - 1) begin
        sent_q.push_back(cur);
        if (pre != 0) begin
          popped_full = (pre == DEPTH);
          cur = fifo_q.pop_front();
          pos = 0;
        end else begin
          in_frame = 0;
        end
      end else begin
        pos++;
      end
      if (push) fifo_q.push_back(data);
    end
    #1;
    check("line",  {31'd0, serial}, {31'd0, in_frame ? frame_bit(cur, pos) : 1'b1});
    check("ready", {31'd0, ready},  {31'd0, fifo_q.size() != DEPTH});
    check("busy",  {31'd0, busy},   {31'd0, in_frame || (fifo_q.size() != 0)});
    if (rst) begin
      rx_active = 0;
    end else begin
      if (!rx_active) begin
        if (serial == 1'b0) begin
          rx_active = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % D == D/2)) begin
        if (rx_cnt / D == 0) check("rx_start", {31'd0, serial}, 32'd0);
        else if (rx_cnt / D <= 8) rx_byte[rx_cnt/D - 1] = serial;
        else begin
          check("rx_stop", {31'd0, serial}, 32'd1);
          rx_q.push_back(rx_byte);
          rx_active = 0;
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((in_frame || fifo_q.size() != 0 || busy) && n < 2000) begin
      step();
      n++;
    end
    check(tag, {31'd0, n < 2000}, 32'd1);
  endtask

  initial begin
    int n, fall_t, busy_fall, last_edge, edges;
    logic prev;

    // Reset
    step(); step();
    check("rst_serial", {31'd0, serial}, 32'd1);
    check("rst_ready",  {31'd0, ready},  32'd1);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_ready_s", {31'd0, ready_s}, 32'd1);
    rst = 1'b0;
    step(); step();

    // Single byte 0xA5
    valid = 1'b1; data = 8'hA5;
    step();
    valid = 1'b0; data = 8'h00;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) check("a5_fall", {31'd0, serial}, 32'd0);
    end while (busy && n < 200);
    check("a5_busy_fall", n, 81);
    check("a5_decode", {24'd0, rx_q[$]}, 32'hA5);
    step(); step();

    // Back-to-back 0x00, 0xFF
    valid = 1'b1; data = 8'h00; step();
    data = 8'hFF; step();
    valid = 1'b0;
    drain("b2b_drain");
    check("b2b_first",  {24'd0, rx_q[rx_q.size()-2]}, 32'h00);
    check("b2b_second", {24'd0, rx_q[rx_q.size()-1]}, 32'hFF);

    // FIFO full: offer 0x01..0x06 on consecutive cycles
    for (int k = 1; k <= 6; k++) begin
      valid = 1'b1; data = 8'(k);
      step();
      if (k == 5) check("full_ready_low", {31'd0, ready}, 32'd0);
    end
    valid = 1'b0;
    drain("full_drain");
    for (int k = 0; k < 5; k++)
      check("full_order", {24'd0, rx_q[rx_q.size()-5+k]}, k + 1);

    // Write offered on the pop edge while full
    n = 0;
    while (fifo_q.size() < DEPTH && n < 40) begin
      valid = 1'b1; data = 8'(8'h40 + n);
      step();
      n++;
    end
    data = 8'h77;
    n = 0;
    while (!popped_full && n < 400) begin
      step();
      n++;
    end
    valid = 1'b0;
    check("fullpop_seen",  {31'd0, popped_full}, 32'd1);
    check("fullpop_ready", {31'd0, ready}, 32'd1);
    step();
    check("fullpop_ready2", {31'd0, ready}, 32'd1);
    drain("fullpop_drain");

    // Reset during data bit 3 of 0x3C with two bytes queued
    valid = 1'b1; data = 8'h3C; step();
    data = 8'h81; step();
    data = 8'h42; step();
    valid = 1'b0;
    n = 0;
    while (!(in_frame && pos == 4*D + 3) && n < 200) begin
      step();
      n++;
    end
    check("rst_mid_reached", {31'd0, in_frame && cur == 8'h3C}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_serial", {31'd0, serial}, 32'd1);
    check("rst_mid_busy",   {31'd0, busy},   32'd0);
    check("rst_mid_ready",  {31'd0, ready},  32'd1);
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 30*D; k++) step();
    check("rst_mid_idle", {31'd0, serial}, 32'd1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      valid = ($urandom_range(0, 99) < 30);
      data  = 8'($urandom);
      step();
    end
    valid = 1'b0;
    drain("rand_drain");
    check("rx_count", rx_q.size(), sent_q.size());
    for (int k = 0; k < rx_q.size() && k < sent_q.size(); k++)
      check("rx_byte", {24'd0, rx_q[k]}, {24'd0, sent_q[k]});

    // Default divider: 0x55 toggles every bit, so each run is one bit period
    valid_s = 1'b1; data_s = 8'h55;
    @(posedge clk); #1;
    valid_s = 1'b0;
    n = 0; fall_t = -1; busy_fall = -1; last_edge = 0; edges = 0; prev = 1'b1;
    while (busy_fall < 0 && n < 10000) begin
      @(posedge clk); #1;
      n++;
      if (serial_s != prev) begin
        if (fall_t < 0) fall_t = n;
        else check("slow_bit", n - last_edge, DS);
        last_edge = n;
        edges++;
      end
      prev = serial_s;
      if (!busy_s) busy_fall = n;
    end
    check("slow_done",  {31'd0, busy_fall >= 0}, 32'd1);
    check("slow_fall",  fall_t, 1);
    check("slow_edges", edges, 10);
    check("slow_stop",  busy_fall - last_edge, DS);
    check("slow_frame", busy_fall - fall_t, 10*DS);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

`default_nettype wire
